fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/glcpu_pkg.sv | 41 ++++
 rtl/fetch_watchdog.sv | 32 +++
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/glcpu_pkg.sv
// Shared types for the glcpu fetch front end:
// sequencer states, opcode mode field and control strobe bundle.
package glcpu_pkg;

  typedef enum logic [2:0] {
    BOOT,
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    LOAD_ADDR,
    ISSUE,
    FAULT
  } state_t;

  localparam int MODE_MSB = 7;
  localparam int MODE_LSB = 6;

  localparam logic [1:0] MODE_IMPL = 2'b00;
  localparam logic [1:0] MODE_IMM  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_JMP  = 2'b11;

  typedef struct packed {
    logic memRead;
    logic pcInc;
    logic pcLoad;
    logic arInc;
    logic arLoad;
    logic tlLoad;
    logic thLoad;
    logic sel;
    logic opValid;
  } ctrl_t;

  function automatic logic [1:0] opMode(
    input logic [7:0] op
  );
    return op[MODE_MSB:MODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Stall counter for the fetch states; flags the cycle in
// which the wait limit is reached (FETCH_TIMEOUT_EN builds).
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic take,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] TOP  = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (take) begin
      count <= '0;
    end else if (stall && count != TOP) begin
      count <= count + 1'b1;
    end
  end

  // the stall cycle that brings count to the limit
  assign expire = stall && (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: gathers opcode/operand bytes and
// drives address-register strobes. Option: FETCH_TIMEOUT_EN.
module fetch_sequencer
  import glcpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] memData,
  input  logic       memReady,
  input  logic       opReady,
  input  logic       execArInc,
  output logic       memRead,
  output logic       pcInc,
  output logic       pcLoad,
  output logic       arInc,
  output logic       arLoad,
  output logic       tlLoad,
  output logic       thLoad,
  output logic       sel,
  output logic [7:0] opcode,
  output logic [7:0] immData,
  output logic       opValid,
  output logic       fault
);

  state_t     state;
  state_t     nextState;
  ctrl_t      ctrl;
  ctrl_t      ctrlOut;
  logic [1:0] mode;
  logic       fetching;
  logic       take;
  logic       expire;

  assign mode     = opMode(opcode);
  assign fetching = (state == FETCH_OP) ||
                    (state == FETCH_LO) ||
                    (state == FETCH_HI);
  assign take     = fetching && memReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode  <= 8'h00;
      immData <= 8'h00;
    end else begin
      if (state == FETCH_OP && take) begin
        opcode <= memData;
      end
      if (state == FETCH_LO && take &&
          mode == MODE_IMM) begin
        immData <= memData;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      BOOT: nextState = FETCH_OP;
      FETCH_OP: begin
        if (take) begin
          nextState =
            (opMode(memData) == MODE_IMPL) ?
            ISSUE : FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (take) begin
          nextState = (mode == MODE_IMM) ?
                      ISSUE : FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (take) nextState = LOAD_ADDR;
      end
      LOAD_ADDR: begin
        nextState = (mode == MODE_JMP) ?
                    FETCH_OP : ISSUE;
      end
      ISSUE: begin
        if (opReady) nextState = FETCH_OP;
      end
      FAULT: nextState = FAULT;
      default: nextState = BOOT;
    endcase
    if (expire) nextState = FAULT;
  end

  always_comb begin
    ctrl = '0;
    unique case (state)
      BOOT: ctrl.sel = 1'b1;
      FETCH_OP: begin
        ctrl.memRead = 1'b1;
        ctrl.sel     = 1'b1;
        ctrl.pcInc   = memReady;
      end
      FETCH_LO: begin
        ctrl.memRead = 1'b1;
        ctrl.sel     = 1'b1;
        ctrl.pcInc   = memReady;
        ctrl.tlLoad  = memReady &&
                       (mode != MODE_IMM);
      end
      FETCH_HI: begin
        ctrl.memRead = 1'b1;
        ctrl.sel     = 1'b1;
        ctrl.pcInc   = memReady;
        ctrl.thLoad  = memReady;
      end
      LOAD_ADDR: begin
        ctrl.arLoad = (mode == MODE_ABS);
        ctrl.pcLoad = (mode == MODE_JMP);
      end
      ISSUE: begin
        ctrl.sel     = 1'b1;
        ctrl.opValid = 1'b1;
        ctrl.arInc   = execArInc;
      end
      default: ctrl = '0;
    endcase
  end

  // BOOT drives sel, so reset must mask strobes directly
  assign ctrlOut = rst ? '0 : ctrl;

  assign memRead = ctrlOut.memRead;
  assign pcInc   = ctrlOut.pcInc;
  assign pcLoad  = ctrlOut.pcLoad;
  assign arInc   = ctrlOut.arInc;
  assign arLoad  = ctrlOut.arLoad;
  assign tlLoad  = ctrlOut.tlLoad;
  assign thLoad  = ctrlOut.thLoad;
  assign sel     = ctrlOut.sel;
  assign opValid = ctrlOut.opValid;

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .stall (fetching && !memReady),
    .take  (take),
    .expire(expire)
  );

  assign fault = (state == FAULT);
`else
  logic unusedTimeout;

  assign unusedTimeout = |TIMEOUT_CYCLES;
  assign expire        = 1'b0;
  assign fault         = 1'b0;
`endif

endmodule
